// File: rtl/serial_slice_driver_if.sv
// Connection between the bit-serial sequencer and one combinational 1-bit ALU slice.
// The sequencer is the master: it presents one bit pair plus a carry and reads back result and cout.
interface serial_slice_driver_if;
    logic [1:0] mode;
    logic       opcode;
    logic       ain;
    logic       bin;
    logic       cin;
    logic       result;
    logic       cout;

    modport master (
        output mode, opcode, ain, bin, cin,
        input  result, cout
    );

    modport slave (
        input  mode, opcode, ain, bin, cin,
        output result, cout
    );
endinterface

// File: rtl/serial_slice_driver.sv
// Runs a WIDTH-bit operation through a 1-bit slice, LSB first, one bit per clock.
// Each bit's cout is fed back as the next bit's cin; done pulses once y/carry_out are final.
module serial_slice_driver #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode_in,
    input  logic                 opcode_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 cin_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     y,
    output logic                 carry_out,
    serial_slice_driver_if.master slice
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_mode;
    logic              r_opcode;
    logic              r_carry;
    logic [CNTW-1:0]   r_k;
    logic [WIDTH-1:0]  r_y;
    logic              r_carry_out;

    logic              w_busy;
    logic              w_done;
    logic              w_ain;
    logic              w_bin;
    logic              w_cin;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_ain        = 1'b0;
        w_bin        = 1'b0;
        w_cin        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                w_ain  = r_a[r_k];
                w_bin  = r_b[r_k];
                w_cin  = r_carry;
                if (r_k == LAST_BIT) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand/data registers; the slice result for bit k lands in y[k] at the end of its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= '0;
            r_opcode    <= 1'b0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_y         <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_mode   <= mode_in;
                        r_opcode <= opcode_in;
                        r_carry  <= cin_in;
                        r_k      <= '0;
                        r_y      <= '0;
                    end
                end
                S_RUN: begin
                    r_y[r_k] <= slice.result;
                    r_carry  <= slice.cout;
                    if (r_k == LAST_BIT) begin
                        r_carry_out <= slice.cout;
                    end else begin
                        r_k <= r_k + CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = w_busy;
    assign done         = w_done;
    assign y            = r_y;
    assign carry_out    = r_carry_out;
    assign slice.mode   = r_mode;
    assign slice.opcode = r_opcode;
    assign slice.ain    = w_ain;
    assign slice.bin    = w_bin;
    assign slice.cin    = w_cin;

endmodule

// File: tb/tb_serial_slice_driver.sv
// Bench for serial_slice_driver: a 1-bit add/subtract slice model, an arithmetic reference
// model of the whole operation, a per-cycle compare process and directed/random stimulus.
module tb_serial_slice_driver;

    localparam int WIDTH = 8;
    localparam int CNTW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode_in;
    logic             opcode_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             carry_out;

    int tests  = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    serial_slice_driver_if sif ();

    serial_slice_driver #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode_in   (mode_in),
        .opcode_in (opcode_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .carry_out (carry_out),
        .slice     (sif)
    );

    always #5 clk = ~clk;

    // Slice: full adder, opcode 1 inverts b (a - b when cin = 1).
    logic w_beff;
    assign w_beff     = sif.bin ^ sif.opcode;
    assign sif.result = sif.ain ^ w_beff ^ sif.cin;
    assign sif.cout   = (sif.ain & w_beff) | (sif.ain & sif.cin) | (w_beff & sif.cin);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] low_mask(input int j);
        logic [WIDTH:0] m;
        m = '0;
        for (int i = 0; i < j; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] eff_b(input logic [WIDTH-1:0] b, input logic op);
        return op ? ~b : b;
    endfunction

    // Carry entering bit j = bit j of the sum of the operands' low j bits plus cin.
    function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic op, input logic c, input int j);
        logic [WIDTH:0] s;
        s = ({1'b0, a} & low_mask(j)) + ({1'b0, eff_b(b, op)} & low_mask(j)) + {{WIDTH{1'b0}}, c};
        return s[j];
    endfunction

    // Reference model: m_t = -1 idle, 0..WIDTH-1 bit presented, WIDTH the done cycle.
    int               m_t = -1;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic             m_op = 1'b0;
    logic             m_cin = 1'b0;
    logic [1:0]       m_mode = '0;
    logic [WIDTH:0]   m_sum = '0;
    logic [WIDTH-1:0] m_y = '0;
    logic             m_co = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_t <= -1; m_a <= '0; m_b <= '0; m_op <= 1'b0; m_cin <= 1'b0;
            m_mode <= '0; m_y <= '0; m_co <= 1'b0;
        end else if (m_t < 0) begin
            if (start) begin
                m_t    <= 0;
                m_a    <= a_in;
                m_b    <= b_in;
                m_op   <= opcode_in;
                m_cin  <= cin_in;
                m_mode <= mode_in;
                m_sum  <= {1'b0, a_in} + {1'b0, eff_b(b_in, opcode_in)} + {{WIDTH{1'b0}}, cin_in};
                m_y    <= '0;
            end
        end else if (m_t < WIDTH) begin
            m_t <= m_t + 1;
            m_y <= WIDTH'(m_sum & low_mask(m_t + 1));
            if (m_t + 1 == WIDTH) m_co <= m_sum[WIDTH];
        end else begin
            m_t <= -1;
        end
    end

    logic prev_cout = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit run = (m_t >= 0) && (m_t < WIDTH);
            check("busy",      busy,       (m_t >= 0));
            check("done",      done,       (m_t == WIDTH));
            check("ain",       sif.ain,    run ? m_a[m_t] : 1'b0);
            check("bin",       sif.bin,    run ? m_b[m_t] : 1'b0);
            check("cin",       sif.cin,    run ? carry_into(m_a, m_b, m_op, m_cin, m_t) : 1'b0);
            check("mode",      sif.mode,   m_mode);
            check("opcode",    sif.opcode, m_op);
            check("y",         y,          m_y);
            check("carry_out", carry_out,  m_co);
            if (run && m_t > 0) check("cin_vs_prev_cout", sif.cin, prev_cout);
        end
        prev_cout <= sif.cout;
    end

    // One-cycle start pulse; records ain per bit and the cycle (after the start edge) where done shows.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic op,
                          output logic [WIDTH-1:0] seq, output int lat);
        @(posedge clk); #2;
        start = 1'b1; a_in = a; b_in = b; cin_in = c; opcode_in = op;
        @(posedge clk); #2;
        start = 1'b0;
        a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
        cin_in = 1'($urandom); opcode_in = 1'($urandom);
        seq = '0;
        lat = -1;
        for (int n = 1; n <= 3 * WIDTH; n++) begin
            @(negedge clk);
            if (n <= WIDTH) seq[n-1] = sif.ain;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] seq;
        int               lat;
        int               done_cnt;

        reset = 1'b1; start = 1'b0; mode_in = 2'd1; opcode_in = 1'b0;
        a_in = '0; b_in = '0; cin_in = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("idle_done_pulses", done_cnt, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_y", y, '0);

        run_op(8'd5, 8'd6, 1'b0, 1'b0, seq, lat);
        check("add_ain_seq", seq, 8'b0000_0101);
        check("add_latency", lat, WIDTH + 1);
        check("add_y", y, 8'h0B);
        check("add_cout", carry_out, 1'b0);

        run_op(8'd200, 8'd100, 1'b0, 1'b0, seq, lat);
        check("chain_y", y, 8'h2C);
        check("chain_cout", carry_out, 1'b1);

        run_op(8'd6, 8'd5, 1'b1, 1'b1, seq, lat);
        check("sub_y", y, 8'h01);
        check("sub_cout", carry_out, 1'b1);

        run_op(8'd5, 8'd6, 1'b1, 1'b1, seq, lat);
        check("subneg_y", y, 8'hFF);
        check("subneg_cout", carry_out, 1'b0);

        // start held high with fresh operands every cycle
        @(posedge clk); #2;
        start = 1'b1;
        done_cnt = 0;
        repeat (4 * (WIDTH + 2)) begin
            a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
            cin_in = 1'($urandom); opcode_in = 1'($urandom); mode_in = 2'($urandom);
            @(negedge clk);
            if (done) done_cnt++;
            @(posedge clk); #2;
        end
        start = 1'b0;
        check("held_start_ops", done_cnt, 4);

        repeat (20) begin
            automatic logic [WIDTH-1:0] ra = WIDTH'($urandom);
            automatic logic [WIDTH-1:0] rb = WIDTH'($urandom);
            mode_in = 2'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(ra, rb, 1'($urandom), 1'($urandom), seq, lat);
            check("rand_latency", lat, WIDTH + 1);
        end

        // reset while bit 4 of an add is on the slice
        mode_in = 2'd1;
        @(posedge clk); #2;
        start = 1'b1; a_in = 8'd5; b_in = 8'd6; cin_in = 1'b0; opcode_in = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_y", y, '0);
        check("rst_carry_out", carry_out, 1'b0);
        check("rst_mode", sif.mode, 2'd0);
        check("rst_ain", sif.ain, 1'b0);
        done_cnt = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);

        run_op(8'd5, 8'd6, 1'b0, 1'b0, seq, lat);
        check("post_rst_y", y, 8'h0B);
        check("post_rst_latency", lat, WIDTH + 1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
